// File: rtl/updn_ctr_pkg.sv
// updn_ctr_pkg: shared constants and helpers for the up/down counter.
//   DIR_UP / DIR_DN : up_dn encodings
//   LOAD_ACTIVE     : level of load that selects a parallel load
//   all_ones(w)     : terminal (all-ones) value for a w-bit counter, w in 1..32
package updn_ctr_pkg;

    localparam logic DIR_UP      = 1'b1;
    localparam logic DIR_DN      = 1'b0;
    localparam logic LOAD_ACTIVE = 1'b0;

    function automatic logic [31:0] all_ones(input int unsigned w);
        logic [31:0] v;
        v = '0;
        for (int i = 0; i < 32; i++) begin
            if (i < int'(w)) v[i] = 1'b1;
        end
        return v;
    endfunction

endpackage

// File: rtl/updn_ctr_tc.sv
// updn_ctr_tc: combinational terminal-count decoder.
//   count  : current counter value
//   up_dn  : direction (1 = up, 0 = down)
//   tercnt : 1 when count sits at the terminal value for the direction
//            (all-ones counting up, zero counting down)
module updn_ctr_tc
    import updn_ctr_pkg::*;
#(
    parameter int width = 4
) (
    input  logic [width-1:0] count,
    input  logic             up_dn,
    output logic             tercnt
);

    localparam logic [31:0]      TERM32 = all_ones(width);
    localparam logic [width-1:0] TERM   = TERM32[width-1:0];

    assign tercnt = (up_dn == DIR_UP) ? (count == TERM) : (count == '0);

endmodule

// File: rtl/updn_ctr.sv
// updn_ctr: parameterizable up/down counter with parallel load, count
// enable and terminal-count flag.
//   clk    : rising-edge clock
//   rst    : asynchronous reset, active-high (count -> 0)
//   data   : parallel load value
//   up_dn  : direction, 1 = up, 0 = down
//   load   : active-low synchronous load (wins over cen/up_dn)
//   cen    : count enable
//   count  : registered counter value
//   tercnt : combinational terminal-count flag from count and up_dn
// Build option: define UPDN_CTR_SAT_EN to saturate at the ends instead of
// wrapping modulo 2^width.
module updn_ctr
    import updn_ctr_pkg::*;
#(
    parameter int width = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [width-1:0] data,
    input  logic             up_dn,
    input  logic             load,
    input  logic             cen,
    output logic [width-1:0] count,
    output logic             tercnt
);

    localparam logic [31:0]      TERM32 = all_ones(width);
    localparam logic [width-1:0] TERM   = TERM32[width-1:0];
    localparam logic [width-1:0] ONE    = {{(width-1){1'b0}}, 1'b1};

    logic [width-1:0] count_q;
    logic [width-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load == LOAD_ACTIVE) begin
            count_d = data;
        end else if (cen) begin
            if (up_dn == DIR_UP) begin
`ifdef UPDN_CTR_SAT_EN
                count_d = (count_q == TERM) ? count_q : count_q + ONE;
`else
                count_d = count_q + ONE;
`endif
            end else begin
`ifdef UPDN_CTR_SAT_EN
                count_d = (count_q == '0) ? count_q : count_q - ONE;
`else
                count_d = count_q - ONE;
`endif
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) count_q <= '0;
        else     count_q <= count_d;
    end

    assign count = count_q;

    updn_ctr_tc #(.width(width)) u_tc (
        .count  (count_q),
        .up_dn  (up_dn),
        .tercnt (tercnt)
    );

endmodule

// File: tb/tb_updn_ctr.sv
module tb_updn_ctr;

    logic       clk;
    logic       rst;
    logic [3:0] data;
    logic       up_dn;
    logic       load;
    logic       cen;
    logic [3:0] count;
    logic       tercnt;

    int checks = 0;
    int errors = 0;
    int m      = 0;   // reference counter value, plain integer 0..15

    updn_ctr #(.width(4)) dut (
        .clk    (clk),
        .rst    (rst),
        .data   (data),
        .up_dn  (up_dn),
        .load   (load),
        .cen    (cen),
        .count  (count),
        .tercnt (tercnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int exp_tc();
        return up_dn ? int'(m == 15) : int'(m == 0);
    endfunction

    // Advance the reference by the rules of one edge, then clock the DUT
    // and compare just after the edge.
    task automatic tick(input string tag);
        if (!rst) begin
            if (!load) m = int'(data);
            else if (cen) begin
`ifdef UPDN_CTR_SAT_EN
                if (up_dn) m = (m == 15) ? 15 : m + 1;
                else       m = (m == 0)  ? 0  : m - 1;
`else
                if (up_dn) m = (m + 1) % 16;
                else       m = (m + 15) % 16;
`endif
            end
        end else m = 0;
        @(posedge clk);
        #1;
        check({tag, "_count"}, 32'(count), m);
        check({tag, "_tercnt"}, 32'(tercnt), exp_tc());
    endtask

    initial begin
        // reset
        rst = 1'b1; up_dn = 1'b1; load = 1'b1; cen = 1'b0; data = 4'd0;
        #2;
        check("rst_count", 32'(count), 0);
        check("rst_tc_up", 32'(tercnt), 0);
        up_dn = 1'b0;
        #1;
        check("rst_tc_dn", 32'(tercnt), 1);
        @(posedge clk); #1;
        rst = 1'b0; up_dn = 1'b1;
        m = 0;

        // load 7, then hold
        load = 1'b0; data = 4'd7; cen = 1'b0;
        tick("load7");
        check("load7_const", 32'(count), 7);
        load = 1'b1;
        for (int i = 0; i < 5; i++) tick("hold");
        check("hold_const", 32'(count), 7);

        // count up to 15, then wrap/saturate
        cen = 1'b1; up_dn = 1'b1;
        for (int i = 0; i < 8; i++) tick("up");
        check("up15", 32'(count), 15);
        check("up15_tc", 32'(tercnt), 1);
        tick("upwrap");
`ifdef UPDN_CTR_SAT_EN
        check("upsat", 32'(count), 15);
`else
        check("upwrap0", 32'(count), 0);
        check("upwrap_tc", 32'(tercnt), 0);
`endif

        // load 3, count down to 0, then wrap/saturate
        load = 1'b0; data = 4'd3;
        tick("load3");
        load = 1'b1; up_dn = 1'b0; cen = 1'b1;
        for (int i = 0; i < 3; i++) tick("dn");
        check("dn0", 32'(count), 0);
        check("dn0_tc", 32'(tercnt), 1);
        tick("dnwrap");
`ifdef UPDN_CTR_SAT_EN
        check("dnsat", 32'(count), 0);
`else
        check("dnwrap15", 32'(count), 15);
`endif

        // load has priority over counting
        load = 1'b0; cen = 1'b1; up_dn = 1'b1; data = 4'd9;
        tick("prio");
        check("prio9", 32'(count), 9);

        // async reset between edges while counting
        load = 1'b1; cen = 1'b1; up_dn = 1'b1;
        tick("cnt");
        tick("cnt");
        #3;
        rst = 1'b1;
        #1;
        m = 0;
        check("async_rst", 32'(count), 0);
        check("async_rst_tc", 32'(tercnt), 0);
        @(posedge clk); #1;
        check("rst_hold", 32'(count), 0);
        rst = 1'b0;

        // randomized traffic against the reference
        for (int i = 0; i < 300; i++) begin
            data  = 4'($urandom_range(0, 15));
            load  = ($urandom_range(0, 7) != 0);
            cen   = ($urandom_range(0, 3) != 0);
            up_dn = 1'($urandom_range(0, 1));
            #1;
            // tercnt follows up_dn without waiting for an edge
            check("rnd_tc_now", 32'(tercnt), exp_tc());
            tick("rnd");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
